timer_controller: RTL



---
 rtl/timer_defs_pkg.sv | 18 +
 rtl/timer_controller_interval_counter.sv | 32 +++
 rtl/timer_controller.sv | 119 +++++++++++
 3 files changed

// File: rtl/timer_defs_pkg.sv
// Shared command and state encodings for the timer controller slice.
package timer_defs;

    typedef logic [1:0] op_t;
    typedef logic [1:0] state_t;

    // Command opcodes carried on cmd_op
    localparam op_t OP_LOAD  = 2'b00;
    localparam op_t OP_START = 2'b01;
    localparam op_t OP_STOP  = 2'b10;
    localparam op_t OP_CLEAR = 2'b11;

    // Controller states, also visible on the state_dbg output
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/timer_controller_interval_counter.sv
// Cycle counter for one timer interval: counts while enabled, restarts on a
// synchronous clear, and flags the last cycle of the interval on wrap.
module interval_counter #(
    parameter int PERIOD_W = 32
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                en,
    input  logic                clr,
    input  logic [PERIOD_W-1:0] period,
    output logic                wrap
);

    localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

    logic [PERIOD_W-1:0] r_ticks;

    // Last cycle of the interval; period is never 0, so period-1 cannot underflow
    always_comb wrap = en && (r_ticks == (period - ONE));

    // Count while enabled; clear and wrap both restart the interval at zero
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ticks <= '0;
        end else if (clr || wrap) begin
            r_ticks <= '0;
        end else if (en) begin
            r_ticks <= r_ticks + ONE;
        end
    end

endmodule

// File: rtl/timer_controller.sv
// Command-driven timer: programmable period, start/stop/clear, one-shot or
// periodic mode, producing a tick pulse, an event counter and a flipper.
//
// Command handshake: a command transfers on a rising CLK edge where
// cmd_valid && cmd_ready; cmd_op/cmd_arg/cmd_oneshot are sampled only on that
// edge. cmd_ready drops for exactly the cycle after each transfer and is 1
// otherwise. Commands that make no sense in the current state are still
// accepted (and cost the same ready cycle) but have no effect.
module timer_controller
    import timer_defs::*;
#(
    parameter int                  PERIOD_W       = 32,
    parameter logic [PERIOD_W-1:0] DEFAULT_PERIOD = PERIOD_W'(12000000),
    parameter int                  COUNT_W        = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [PERIOD_W-1:0] cmd_arg,
    input  logic                cmd_oneshot,
    output logic                running,
    output logic                done,
    output logic [COUNT_W-1:0]  counter,
    output logic                flipper,
    output logic                tick,
    output logic [1:0]          state_dbg
);

    localparam logic [PERIOD_W-1:0] ONE_P = PERIOD_W'(1);
    localparam logic [COUNT_W-1:0]  ONE_C = COUNT_W'(1);

    state_t              state;
    state_t              state_nxt;
    logic [PERIOD_W-1:0] period;
    logic                mode_oneshot;
    logic                accept;
    logic                wrap;
    logic                fire;
    logic                ticks_clr;
    logic                is_clear;

    assign accept    = cmd_valid && cmd_ready;
    assign is_clear  = accept && (cmd_op == OP_CLEAR);
    // CLEAR landing on the wrap edge swallows that tick
    assign fire      = wrap && !is_clear;
    // Interval restarts on LOAD, CLEAR, and a START that leaves DONE
    assign ticks_clr = accept && ((cmd_op == OP_LOAD) || (cmd_op == OP_CLEAR) ||
                                  ((cmd_op == OP_START) && (state == ST_DONE)));

    assign running   = (state == ST_RUN);
    assign done      = (state == ST_DONE);
    assign state_dbg = state;

    interval_counter #(
        .PERIOD_W (PERIOD_W)
    ) u_interval (
        .CLK    (CLK),
        .RST    (RST),
        .en     (state == ST_RUN),
        .clr    (ticks_clr),
        .period (period),
        .wrap   (wrap)
    );

    // Next state: one-shot expiry first, then an accepted command may override it
    always_comb begin
        state_nxt = state;
        if ((state == ST_RUN) && fire && mode_oneshot) begin
            state_nxt = ST_DONE;
        end
        if (accept) begin
            case (cmd_op)
                OP_START: if (state != ST_RUN)  state_nxt = ST_RUN;
                OP_STOP:  if (state != ST_IDLE) state_nxt = ST_IDLE;
                default:  ;
            endcase
        end
    end

    // State, handshake, period and mode registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= ST_IDLE;
            cmd_ready    <= 1'b1;
            period       <= DEFAULT_PERIOD;
            mode_oneshot <= 1'b0;
        end else begin
            state     <= state_nxt;
            cmd_ready <= !accept;
            if (accept && (cmd_op == OP_LOAD)) begin
                period <= (cmd_arg == '0) ? ONE_P : cmd_arg;
            end
            if (accept && (cmd_op == OP_START) && (state != ST_RUN)) begin
                mode_oneshot <= cmd_oneshot;
            end
        end
    end

    // Tick pulse, event counter and flipper
    always_ff @(posedge CLK) begin
        if (RST) begin
            tick    <= 1'b0;
            counter <= '0;
            flipper <= 1'b0;
        end else begin
            tick <= fire;
            if (is_clear) begin
                counter <= '0;
                flipper <= 1'b0;
            end else if (fire) begin
                counter <= counter + ONE_C;
                flipper <= !flipper;
            end
        end
    end

endmodule
